// File: rtl/mac_src_pkg.sv
// mac_src_pkg: shared widths and FSM state type for the accumulator sample source
package mac_src_pkg;
  localparam int SAMPLE_W = 8;
  localparam int ACC_W = 20;
  typedef enum logic [1:0] {IDLE, SEND, GAP} src_state_t;
endpackage

// File: rtl/mac_sample_source_if.sv
// mac_sample_source_if: host write, burst control and accumulator stream signals
// exp_sum exists only when MAC_SOURCE_EXPSUM_EN is defined
interface mac_sample_source_if #(parameter int DEPTH = 8, parameter int LEN_W = 8, parameter int GAP_W = 4);
  import mac_src_pkg::*;
  logic wr_en;
  logic [SAMPLE_W-1:0] wr_data;
  logic full;
  logic [$clog2(DEPTH):0] count;
  logic start;
  logic [LEN_W-1:0] burst_len;
  logic [GAP_W-1:0] gap;
  logic [SAMPLE_W-1:0] a_out;
  logic valid_out;
  logic busy;
  logic done;
  logic underrun;
`ifdef MAC_SOURCE_EXPSUM_EN
  logic [ACC_W-1:0] exp_sum;
  modport master (input wr_en, wr_data, start, burst_len, gap,
                  output full, count, a_out, valid_out, busy, done, underrun, exp_sum);
  modport slave (output wr_en, wr_data, start, burst_len, gap,
                 input full, count, a_out, valid_out, busy, done, underrun, exp_sum);
`else
  modport master (input wr_en, wr_data, start, burst_len, gap,
                  output full, count, a_out, valid_out, busy, done, underrun);
  modport slave (output wr_en, wr_data, start, burst_len, gap,
                 input full, count, a_out, valid_out, busy, done, underrun);
`endif
endinterface

// File: rtl/mac_src_fifo.sv
// mac_src_fifo: synchronous FIFO; full is judged before a same-edge pop, no bypass
module mac_src_fifo #(parameter int DEPTH = 8, parameter int W = 8) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/mac_sample_source.sv
// mac_sample_source: FIFO-buffered, gap-paced burst driver for the accumulator a/valid stream
// Optional MAC_SOURCE_EXPSUM_EN adds exp_sum, the running sum of squares of emitted samples
module mac_sample_source import mac_src_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 8,
  parameter int GAP_W = 4
) (
  input logic clk,
  input logic reset,
  mac_sample_source_if.master bus
);
  src_state_t state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [GAP_W-1:0] gap_l, gap_n, gcnt, gcnt_n;
  logic [SAMPLE_W-1:0] a_q, a_n, head;
  logic valid_q, valid_n, done_q, done_n, und_q, und_n, busy_q, busy_n;
  logic pop, empty;
  mac_src_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk(clk), .reset(reset), .push(bus.wr_en), .pop(pop), .din(bus.wr_data),
    .dout(head), .full(bus.full), .empty(empty), .count(bus.count)
  );
  // A SEND visit with rem==0 is the closing cycle; zero-length bursts reuse it
  always_comb begin
    state_n = state;
    rem_n = rem;
    gap_n = gap_l;
    gcnt_n = gcnt;
    a_n = a_q;
    valid_n = 1'b0;
    done_n = 1'b0;
    und_n = 1'b0;
    busy_n = busy_q;
    pop = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_n = SEND;
        rem_n = bus.burst_len;
        gap_n = bus.gap;
        gcnt_n = '0;
        busy_n = 1'b1;
      end
      SEND: if (rem == '0) begin
        state_n = IDLE;
        done_n = 1'b1;
        busy_n = 1'b0;
      end else if (!empty) begin
        pop = 1'b1;
        a_n = head;
        valid_n = 1'b1;
        rem_n = rem - 1'b1;
        gcnt_n = '0;
        state_n = (rem != LEN_W'(1) && gap_l != '0) ? GAP : SEND;
      end else und_n = 1'b1;
      default: begin
        gcnt_n = gcnt + 1'b1;
        state_n = (gcnt == gap_l - 1'b1) ? SEND : GAP;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      gap_l <= '0;
      gcnt <= '0;
      a_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      und_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      gap_l <= gap_n;
      gcnt <= gcnt_n;
      a_q <= a_n;
      valid_q <= valid_n;
      done_q <= done_n;
      und_q <= und_n;
      busy_q <= busy_n;
    end
  end
  assign bus.a_out = a_q;
  assign bus.valid_out = valid_q;
  assign bus.done = done_q;
  assign bus.underrun = und_q;
  assign bus.busy = busy_q;
`ifdef MAC_SOURCE_EXPSUM_EN
  logic [ACC_W-1:0] sum_q;
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && bus.start)) sum_q <= '0;
    else if (pop) sum_q <= sum_q + ACC_W'(head) * ACC_W'(head);
  end
  assign bus.exp_sum = sum_q;
`endif
endmodule
